count_monitor: RTL and testbench

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_monitor.sv | 107 ++++++++++
 tb/tb_count_monitor.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// Checks a 4-bit counter and its decode output cycle by cycle, reporting lock, sticky error, error and wrap counts.
// Define BOOL_CHECK_EN to also check the Boolean decode input against F(count); otherwise Boolean is ignored.
module count_monitor (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Input,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       Boolean,
    input  logic       Clear,
    output logic       Locked,
    output logic       Error,
    output logic       Mismatch,
    output logic [3:0] ErrCount,
    output logic [7:0] WrapCount
);

    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] prev;
    logic       prev_en;
    logic [3:0] cnt;
    logic [3:0] exp_cnt;
    logic       cnt_mis;
    logic       bool_mis;
    logic       any_mis;
    logic       wrap_hit;

`ifdef BOOL_CHECK_EN
    function automatic logic decode_f(input logic [3:0] c);
        logic a, b, cc, d;
        {d, cc, b, a} = c;
        return (~a & d) | (a & b & cc) | (~cc & d & b) | (a & ~b & cc & d);
    endfunction
`endif

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_comb begin
        cnt      = {D, C, B, A};
        exp_cnt  = prev + {3'b000, prev_en};
        cnt_mis  = (state != IDLE) && (cnt != exp_cnt);
`ifdef BOOL_CHECK_EN
        bool_mis = (Boolean != decode_f(cnt));
`else
        // Decode input is deliberately ignored in this build.
        bool_mis = Boolean & 1'b0;
`endif
        any_mis  = cnt_mis | bool_mis;
        wrap_hit = (state != IDLE) && (prev == 4'hF) && prev_en && (cnt == 4'h0) && !cnt_mis;
    end

    always_comb begin
        state_next = state;
        if (Clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = any_mis ? FAULT : TRACK;
                TRACK:   state_next = any_mis ? FAULT : TRACK;
                FAULT:   state_next = FAULT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            prev      <= 4'h0;
            prev_en   <= 1'b0;
            Locked    <= 1'b0;
            Error     <= 1'b0;
            Mismatch  <= 1'b0;
            ErrCount  <= 4'h0;
            WrapCount <= 8'h00;
        end else begin
            state  <= state_next;
            Locked <= (state_next == TRACK);
            if (Clear) begin
                // Clear discards this cycle's sample; prev/prev_en are reloaded by the next IDLE sample.
                Error     <= 1'b0;
                Mismatch  <= 1'b0;
                ErrCount  <= 4'h0;
                WrapCount <= 8'h00;
            end else begin
                prev     <= cnt;
                prev_en  <= Input;
                Mismatch <= any_mis;
                if (any_mis) begin
                    Error    <= 1'b1;
                    ErrCount <= sat_inc4(ErrCount);
                end
                if (wrap_hit) begin
                    WrapCount <= WrapCount + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: a vector table for counting/fault behaviour plus hand sequences for corners.
module tb_count_monitor;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Input = 1'b0;
    logic       A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
    logic       Boolean = 1'b0;
    logic       Clear = 1'b0;
    logic       Locked, Error, Mismatch;
    logic [3:0] ErrCount;
    logic [7:0] WrapCount;

    int n_checks = 0;
    int n_fail   = 0;

    count_monitor dut (
        .Clock(Clock), .Reset(Reset), .Input(Input),
        .A(A), .B(B), .C(C), .D(D),
        .Boolean(Boolean), .Clear(Clear),
        .Locked(Locked), .Error(Error), .Mismatch(Mismatch),
        .ErrCount(ErrCount), .WrapCount(WrapCount)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] cnt;
        logic       clr;
        logic       locked;
        logic       error;
        logic       mis;
        logic [3:0] errc;
        logic [7:0] wrap;
    } vec_t;

    vec_t tbl[25];

    function automatic logic f_model(input logic [3:0] c);
        logic a, b, cc, d;
        a = c[0]; b = c[1]; cc = c[2]; d = c[3];
        return (~a & d) | (a & b & cc) | (~cc & d & b) | (a & ~b & cc & d);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic l, input logic e, input logic m,
                           input logic [3:0] ec, input logic [7:0] w);
        chk({name, ".Locked"},    Locked,    l);
        chk({name, ".Error"},     Error,     e);
        chk({name, ".Mismatch"},  Mismatch,  m);
        chk({name, ".ErrCount"},  ErrCount,  ec);
        chk({name, ".WrapCount"}, WrapCount, w);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        #1;
        Reset = 1'b0;
    endtask

    task automatic step(input logic en, input logic [3:0] c, input logic bv, input logic clr);
        Input = en;
        {D, C, B, A} = c;
        Boolean = bv;
        Clear = clr;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        // Scenario 1: correct counting from reset for 20 edges, one wrap at edge 16.
        for (int i = 0; i < 20; i++) begin
            tbl[i] = '{rst: (i == 0), en: 1'b1, cnt: 4'(i % 16), clr: 1'b0,
                       locked: 1'b1, error: 1'b0, mis: 1'b0, errc: 4'h0,
                       wrap: (i >= 16) ? 8'd1 : 8'd0};
        end
        // Scenario 2: 0,1,2 then 5 where 3 is expected, then resynchronised 6.
        tbl[20] = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
        tbl[21] = '{1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
        tbl[22] = '{1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
        tbl[23] = '{1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 8'd0};
        tbl[24] = '{1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 8'd0};

        @(posedge Clock);
        #1;
        for (int i = 0; i < 25; i++) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].en, tbl[i].cnt, f_model(tbl[i].cnt), tbl[i].clr);
            chk_all($sformatf("vec%0d", i), tbl[i].locked, tbl[i].error, tbl[i].mis,
                    tbl[i].errc, tbl[i].wrap);
        end

        // Scenario 3: count held at 7, enable low, Boolean wrongly 0.
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            step(1'b0, 4'd7, 1'b0, 1'b0);
`ifdef BOOL_CHECK_EN
            if (i == 14) chk("hold7.ErrCount14", ErrCount, 4'd14);
`endif
        end
`ifdef BOOL_CHECK_EN
        chk_all("hold7", 1'b0, 1'b1, 1'b1, 4'd15, 8'd0);
`else
        chk_all("hold7", 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
`endif

        // Count mismatch every cycle saturates ErrCount.
        do_reset();
        step(1'b0, 4'd0, f_model(4'd0), 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, (i % 2) ? 4'd1 : 4'd2, f_model((i % 2) ? 4'd1 : 4'd2), 1'b0);
            if (i == 15) chk("sat.ErrCount15", ErrCount, 4'd15);
        end
        chk_all("sat", 1'b0, 1'b1, 1'b1, 4'd15, 8'd0);

        // Scenario 4: Clear in the same cycle as a mismatch, while already faulted.
        do_reset();
        step(1'b1, 4'd0, f_model(4'd0), 1'b0);
        step(1'b1, 4'd5, f_model(4'd5), 1'b0);
        chk_all("preclr", 1'b0, 1'b1, 1'b1, 4'd1, 8'd0);
        step(1'b1, 4'd9, f_model(4'd9), 1'b1);
        chk_all("clr", 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        step(1'b1, 4'd3, f_model(4'd3), 1'b0);
        chk_all("postclr", 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);

        // Scenario 5: three wraps, then asynchronous reset between edges.
        do_reset();
        for (int i = 0; i <= 48; i++) step(1'b1, 4'(i % 16), f_model(4'(i % 16)), 1'b0);
        chk_all("wrap3", 1'b1, 1'b0, 1'b0, 4'd0, 8'd3);
        #2;
        Reset = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        Reset = 1'b0;
        step(1'b0, 4'd9, f_model(4'd9), 1'b0);
        chk_all("first_after_rst", 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);

        // Scenario 6: decode values that must not flag.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 4'd8, 1'b1, 1'b0);
        chk_all("hold8", 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b0, 1'b0);
        chk_all("hold0", 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);

        // WrapCount rolls over modulo 256.
        do_reset();
        for (int i = 0; i <= 4096; i++) begin
            step(1'b1, 4'(i % 16), f_model(4'(i % 16)), 1'b0);
            if (i == 4080) chk("wrap255", WrapCount, 8'd255);
        end
        chk_all("wrap256", 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
